sd_rx_dma_sequencer: RTL
========================

# sd_rx_dma_sequencer

Multi-block receive sequencer for the SD DMA data path. It arms the RX FIFO filler and supplies its Wishbone base address one 512-byte block at a time. It counts completed Wishbone write acknowledges to advance the address, and ends the transfer with a done pulse or an error status. It sits between the host-visible command/register logic and the RX filler, and snoops the filler's master bus handshake.

## Interface
Parameters:
- WORDS_PER_BLK, 128, Wishbone words per SD block (filler offset wraps after this many writes)
- BLK_BYTES, 512, address increment per block
- CNT_W, 16, width of block counters
- TMO_W, 16, width of ack-timeout counter

Ports:
- clk  in  1  system/Wishbone clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins transfer (ignored while busy)
- abort  in  1  level/pulse; terminates transfer
- base_adr  in  32  destination byte address of block 0 (sampled on start)
- blk_cnt  in  CNT_W  number of blocks (sampled on start)
- tmo_lim  in  TMO_W  max cycles cyc may be high without ack; 0 disables timeout
- rx_crc_err  in  1  single-cycle pulse from serial engine, block CRC failed
- m_wb_cyc_i  in  1  snoop of filler m_wb_cyc_o
- m_wb_ack_i  in  1  snoop of slave ack to filler
- fill_en  out  1  filler enable
- fill_adr  out  32  filler base address
- busy  out  1  transfer in progress
- done  out  1  single-cycle pulse, successful completion
- err  out  1  sticky error flag, cleared by next accepted start
- status  out  3  sticky cause: [0] CRC, [1] timeout, [2] abort
- blks_done  out  CNT_W  blocks fully written in current/last transfer

## Operation
- States: IDLE, RUN, FINISH, FAIL.
- IDLE: fill_en=0, busy=0. On start: latch base_adr→fill_adr, blk_cnt→remaining, clear blks_done/word count/err/status. If blk_cnt==0, go FINISH. Otherwise go RUN.
- RUN: fill_en=1, busy=1. Each cycle with m_wb_cyc_i & m_wb_ack_i increments the word counter (log2(WORDS_PER_BLK) bits). On the ack that completes a block:
  - word counter wraps to 0
  - blks_done increments, fill_adr += BLK_BYTES (32-bit wrap, no carry out)
  - remaining decrements; if it reaches 0, go FINISH
- FINISH: fill_en=0 for exactly one cycle; done=1 that cycle; then IDLE.
- FAIL: fill_en=0, err=1, one cycle, then IDLE. status keeps its bits until the next accepted start.
- Timeout: in RUN, a counter increments while m_wb_cyc_i & !m_wb_ack_i and clears on ack or when cyc is low. Reaching tmo_lim (nonzero) sets status[1] and goes FAIL.
- rx_crc_err in RUN sets status[0] and goes FAIL. The pulse is ignored in other states.
- abort in RUN sets status[2] and goes FAIL. abort in IDLE is ignored. abort in the same cycle as start wins: go FAIL and do not start.
- Priority within RUN, same cycle: abort > crc > timeout > block completion. An error coincident with the final ack goes FAIL, no done pulse, and blks_done still increments.
- Dropping fill_en resets the filler offset and FIFO, so every transfer starts at word 0.

## Timing
- Reset values: fill_en=0, fill_adr=0, busy=0, done=0, err=0, status=0, blks_done=0; state IDLE.
- All outputs are registered.
- start→fill_en high: 1 cycle (the edge after the start cycle).
- fill_adr updates on the clock edge that samples the block-completing ack. The filler cannot raise its next cyc earlier than the following edge, so the new address is always stable before the next write.
- Last ack→done: done asserts on the cycle after the edge sampling the last ack; busy falls with the same edge that drops done.
- Error detect→err high: 1 cycle; fill_en low in the same cycle.
- Reset mid-transfer immediately returns every output to its reset value.

## Structure
- Shared package/defines: WORDS_PER_BLK and BLK_BYTES derived from the existing MEM_OFFSET and SD block-size defines, plus the state encoding and status bit indices.
- One natural sub-module: sd_ack_watchdog (timeout counter with cyc/ack inputs, tmo_lim, expired output). Everything else stays flat.

## Test plan
- base_adr=0x1000_0000, blk_cnt=2, slave acks every write → 256 acks; fill_adr 0x1000_0000 then 0x1000_0200; done pulse once; blks_done=2; err=0.
- blk_cnt=0 start → one-cycle FINISH, fill_en never high, done=1, blks_done=0.
- tmo_lim=8, slave withholds ack after word 5 → status=3'b010, err=1, fill_en low 9 cycles after cyc rises, blks_done=0.
- rx_crc_err coincident with the 128th ack of a single-block transfer → status=3'b001, no done, blks_done=1.
- abort and start in the same cycle → status=3'b100, fill_en never high. A subsequent start clears err and runs normally.
- base_adr=0xFFFF_FE00, blk_cnt=2 → second block fill_adr=0x0000_0000; rst asserted mid-block → all outputs zero asynchronously.

Source files
------------

// File: rtl/sd_rx_dma_sequencer_pkg.sv
// Shared constants, state encoding and status bit positions for the SD RX DMA sequencer.
package sd_rx_dma_sequencer_pkg;

  // Bytes per Wishbone word as seen by the filler, and SD block size in bytes.
  localparam int unsigned MEM_OFFSET  = 4;
  localparam int unsigned SD_BLK_SIZE = 512;

  localparam int unsigned WORDS_PER_BLK_DEF = SD_BLK_SIZE / MEM_OFFSET;
  localparam int unsigned BLK_BYTES_DEF     = SD_BLK_SIZE;

  // Bit positions inside the sticky status vector.
  localparam int unsigned ST_CRC   = 0;
  localparam int unsigned ST_TMO   = 1;
  localparam int unsigned ST_ABORT = 2;
  localparam int unsigned ST_W     = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH,
    S_FAIL
  } state_t;

endpackage

// File: rtl/sd_rx_dma_sequencer_if.sv
// Filler-side bundle: enable/base address towards the RX filler and the
// snooped cyc/ack handshake of its Wishbone master port.
interface sd_rx_dma_sequencer_if;

  logic        fill_en;
  logic [31:0] fill_adr;
  logic        m_wb_cyc_i;
  logic        m_wb_ack_i;

  modport master (
    output fill_en,
    output fill_adr,
    input  m_wb_cyc_i,
    input  m_wb_ack_i
  );

  modport slave (
    input  fill_en,
    input  fill_adr,
    output m_wb_cyc_i,
    output m_wb_ack_i
  );

endinterface

// File: rtl/sd_rx_dma_sequencer_ack_watchdog.sv
// Ack watchdog: counts consecutive cycles with cyc high and no ack while enabled.
module sd_ack_watchdog #(
  parameter int unsigned TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cyc,
  input  logic             ack,
  input  logic [TMO_W-1:0] tmo_lim,
  output logic             expired
);

  logic [TMO_W-1:0] cnt;

  // Stall counter: clears on ack, idle bus or when disabled; saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || !cyc || ack) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

  // A zero limit disables the watchdog.
  always_comb begin
    expired = (tmo_lim != '0) && (cnt >= tmo_lim);
  end

endmodule

// File: rtl/sd_rx_dma_sequencer.sv
// Multi-block RX sequencer: arms the RX filler one block at a time, advances the
// block base address on each block-completing ack, and reports done or error.
module sd_rx_dma_sequencer
  import sd_rx_dma_sequencer_pkg::*;
#(
  parameter int unsigned WORDS_PER_BLK = WORDS_PER_BLK_DEF,
  parameter int unsigned BLK_BYTES     = BLK_BYTES_DEF,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned TMO_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [31:0]           base_adr,
  input  logic [CNT_W-1:0]      blk_cnt,
  input  logic [TMO_W-1:0]      tmo_lim,
  input  logic                  rx_crc_err,
  sd_rx_dma_sequencer_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ST_W-1:0]       status,
  output logic [CNT_W-1:0]      blks_done
);

  localparam int unsigned WC_W = $clog2(WORDS_PER_BLK);

  state_t            state, state_nx;
  logic [WC_W-1:0]   word_cnt;
  logic [CNT_W-1:0]  remaining;
  logic              expired;

  logic              accept;
  logic              status_clr;
  logic [ST_W-1:0]   fail_mask;
  logic              ack_hit;
  logic              blk_end;

  sd_ack_watchdog #(
    .TMO_W (TMO_W)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .en      (state == S_RUN),
    .cyc     (bus.m_wb_cyc_i),
    .ack     (bus.m_wb_ack_i),
    .tmo_lim (tmo_lim),
    .expired (expired)
  );

  // Next-state and per-cycle event decode; error priority is abort > crc > timeout > completion.
  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    status_clr = 1'b0;
    fail_mask  = '0;
    ack_hit    = 1'b0;
    blk_end    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && abort) begin
          // Abort racing a start cancels it; status is replaced, not accumulated.
          state_nx            = S_FAIL;
          status_clr          = 1'b1;
          fail_mask[ST_ABORT] = 1'b1;
        end else if (start) begin
          accept     = 1'b1;
          status_clr = 1'b1;
          state_nx   = (blk_cnt == '0) ? S_FINISH : S_RUN;
        end
      end
      S_RUN: begin
        ack_hit = bus.m_wb_cyc_i && bus.m_wb_ack_i;
        blk_end = ack_hit && (word_cnt == WC_W'(WORDS_PER_BLK - 1));
        if (abort) begin
          state_nx            = S_FAIL;
          fail_mask[ST_ABORT] = 1'b1;
        end else if (rx_crc_err) begin
          state_nx          = S_FAIL;
          fail_mask[ST_CRC] = 1'b1;
        end else if (expired) begin
          state_nx          = S_FAIL;
          fail_mask[ST_TMO] = 1'b1;
        end else if (blk_end && (remaining == CNT_W'(1))) begin
          state_nx = S_FINISH;
        end
      end
      S_FINISH: state_nx = S_IDLE;
      S_FAIL:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // State register; status outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      bus.fill_en <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      bus.fill_en <= (state_nx == S_RUN);
      busy  <= (state_nx != S_IDLE);
      done  <= (state_nx == S_FINISH);
    end
  end

  // Transfer bookkeeping; a block completing alongside an error is still counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.fill_adr <= '0;
      remaining    <= '0;
      blks_done    <= '0;
      word_cnt     <= '0;
    end else if (accept) begin
      bus.fill_adr <= base_adr;
      remaining    <= blk_cnt;
      blks_done    <= '0;
      word_cnt     <= '0;
    end else if (ack_hit) begin
      if (blk_end) begin
        word_cnt     <= '0;
        blks_done    <= blks_done + CNT_W'(1);
        bus.fill_adr <= bus.fill_adr + BLK_BYTES;
        remaining    <= remaining - CNT_W'(1);
      end else begin
        word_cnt <= word_cnt + WC_W'(1);
      end
    end
  end

  // Sticky error flag and cause bits, cleared by an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err    <= 1'b0;
      status <= '0;
    end else begin
      status <= (status_clr ? '0 : status) | fail_mask;
      if (fail_mask != '0) begin
        err <= 1'b1;
      end else if (accept) begin
        err <= 1'b0;
      end
    end
  end

endmodule
